// File: rtl/decode_instruction_reg_fetch.sv
// Byte-serial IA-32 front end: prefixes, opcode (optionally 0F escape) and ModR/M into registered reg/w/d/mod/rm fields.
// Optional feature macro: DECODE_TWO_BYTE_OPCODE_EN enables the 0F escape (MOVZX/MOVSX) second-byte decode.
module decode_instruction_reg_fetch #(
  parameter int MAX_PREFIX = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       code_segment_d,
  input  logic       byte_valid,
  input  logic [7:0] byte_data,
  output logic       byte_ready,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [1:0] bit_width,
  output logic [2:0] register,
  output logic       w_in_instruction,
  output logic       w,
  output logic       d,
  output logic       has_modrm,
  output logic [1:0] mod,
  output logic [2:0] rm,
  output logic       error
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_OPCODE = 3'd1;
  localparam logic [2:0] S_ESCAPE = 3'd2;
  localparam logic [2:0] S_MODRM  = 3'd3;
  localparam logic [2:0] S_OUTPUT = 3'd4;
  localparam logic [2:0] S_ERROR  = 3'd5;

  localparam int CW = $clog2(MAX_PREFIX + 1);

  logic [2:0]    state;
  logic          opsize;
  logic [CW-1:0] pcount;

  logic       accept;
  logic       begin_instr;
  logic       is_prefix;
  logic       is_alu_rm;
  logic       is_reg_op;
  logic       is_mov_imm;
  logic [1:0] width_code;

  assign byte_ready = (state == S_OPCODE) || (state == S_ESCAPE) || (state == S_MODRM);
  assign out_valid  = (state == S_OUTPUT);
  assign error      = (state == S_ERROR);

  assign accept      = byte_valid && byte_ready;
  assign begin_instr = start && ((state == S_IDLE) || (state == S_ERROR) ||
                                 ((state == S_OUTPUT) && out_ready));

  always_comb begin
    is_prefix = 1'b0;
    case (byte_data)
      8'h66, 8'h67, 8'hF0, 8'hF2, 8'hF3,
      8'h26, 8'h2E, 8'h36, 8'h3E, 8'h64, 8'h65: is_prefix = 1'b1;
      default: is_prefix = 1'b0;
    endcase
  end

  // ALU r/m,reg forms live in 00-3F with bit 2 clear; the segment prefixes there all have bit 2 set.
  assign is_alu_rm  = ((byte_data < 8'h40) && !byte_data[2]) ||
                      ((byte_data >= 8'h84) && (byte_data <= 8'h8B));
  assign is_reg_op  = ((byte_data >= 8'h40) && (byte_data <= 8'h5F)) ||
                      ((byte_data >= 8'h90) && (byte_data <= 8'h97));
  assign is_mov_imm = (byte_data >= 8'hB0) && (byte_data <= 8'hBF);
  assign width_code = (code_segment_d ^ opsize) ? 2'b10 : 2'b01;

  always_ff @(posedge clock) begin
    if (reset) begin
      state            <= S_IDLE;
      opsize           <= 1'b0;
      pcount           <= '0;
      bit_width        <= 2'b00;
      register         <= 3'b000;
      w_in_instruction <= 1'b0;
      w                <= 1'b0;
      d                <= 1'b0;
      has_modrm        <= 1'b0;
      mod              <= 2'b00;
      rm               <= 3'b000;
    end else if (begin_instr) begin
      state            <= S_OPCODE;
      opsize           <= 1'b0;
      pcount           <= '0;
      bit_width        <= 2'b00;
      register         <= 3'b000;
      w_in_instruction <= 1'b0;
      w                <= 1'b0;
      d                <= 1'b0;
      has_modrm        <= 1'b0;
      mod              <= 2'b00;
      rm               <= 3'b000;
    end else begin
      case (state)
        S_OPCODE: begin
          if (accept) begin
            if (is_prefix) begin
              if (pcount == CW'(MAX_PREFIX)) begin
                state <= S_ERROR;
              end else begin
                pcount <= pcount + CW'(1);
                if (byte_data == 8'h66) opsize <= 1'b1;
              end
            end else if (is_alu_rm) begin
              w                <= byte_data[0];
              d                <= byte_data[1];
              w_in_instruction <= 1'b1;
              state            <= S_MODRM;
            end else if (is_reg_op) begin
              register  <= byte_data[2:0];
              bit_width <= width_code;
              state     <= S_OUTPUT;
            end else if (is_mov_imm) begin
              register         <= byte_data[2:0];
              w                <= byte_data[3];
              w_in_instruction <= 1'b1;
              bit_width        <= width_code;
              state            <= S_OUTPUT;
`ifdef DECODE_TWO_BYTE_OPCODE_EN
            end else if (byte_data == 8'h0F) begin
              state <= S_ESCAPE;
`endif
            end else begin
              state <= S_ERROR;
            end
          end
        end
`ifdef DECODE_TWO_BYTE_OPCODE_EN
        S_ESCAPE: begin
          if (accept) begin
            if ((byte_data == 8'hB6) || (byte_data == 8'hB7) ||
                (byte_data == 8'hBE) || (byte_data == 8'hBF)) begin
              w_in_instruction <= 1'b1;
              w                <= 1'b1;
              d                <= 1'b1;
              state            <= S_MODRM;
            end else begin
              state <= S_ERROR;
            end
          end
        end
`endif
        S_MODRM: begin
          if (accept) begin
            register  <= byte_data[5:3];
            mod       <= byte_data[7:6];
            rm        <= byte_data[2:0];
            has_modrm <= 1'b1;
            bit_width <= width_code;
            state     <= S_OUTPUT;
          end
        end
        S_OUTPUT: begin
          if (out_ready) state <= S_IDLE;
        end
        default: state <= state;
      endcase
    end
  end

endmodule

// File: tb/tb_decode_instruction_reg_fetch.sv
// Randomized bench for decode_instruction_reg_fetch against an instruction-level reference model.
module tb_decode_instruction_reg_fetch;

  typedef struct packed {
    logic       err;
    logic [1:0] bw;
    logic [2:0] reg_f;
    logic       w_in;
    logic       w;
    logic       d;
    logic       hm;
    logic [1:0] mod;
    logic [2:0] rm;
  } res_t;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       code_segment_d = 1'b0;
  logic       byte_valid = 1'b0;
  logic [7:0] byte_data = 8'h00;
  logic       byte_ready;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [1:0] bit_width;
  logic [2:0] register;
  logic       w_in_instruction;
  logic       w;
  logic       d;
  logic       has_modrm;
  logic [1:0] mod;
  logic [2:0] rm;
  logic       error;

  int   checks = 0;
  int   errors = 0;
  res_t exp_r = '0;
  logic chk_en = 1'b0;
  logic in_opcode = 1'b0;
  logic [7:0] seq[16];

  decode_instruction_reg_fetch #(.MAX_PREFIX(4)) dut (
    .clock(clock), .reset(reset), .start(start), .code_segment_d(code_segment_d),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .out_valid(out_valid), .out_ready(out_ready), .bit_width(bit_width),
    .register(register), .w_in_instruction(w_in_instruction), .w(w), .d(d),
    .has_modrm(has_modrm), .mod(mod), .rm(rm), .error(error)
  );

  always #5 clock = ~clock;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, want);
    end
  endtask

  function automatic logic is_pfx(input logic [7:0] b);
    return b inside {8'h66, 8'h67, 8'hF0, 8'hF2, 8'hF3, 8'h26, 8'h2E, 8'h36, 8'h3E, 8'h64, 8'h65};
  endfunction

  // Walks the byte stream the way the instruction set defines it; reports the result and bytes consumed.
  task automatic model(input logic [7:0] s[16], input logic cs, output res_t r, output int used);
    int np = 0;
    int i = 0;
    logic os = 1'b0;
    logic need_modrm = 1'b0;
    logic [7:0] op;
    logic [7:0] m;
    r = '0;
    while (i < 8 && is_pfx(s[i])) begin
      if (np == 4) begin
        r.err = 1'b1;
        used = i + 1;
        return;
      end
      np++;
      if (s[i] == 8'h66) os = 1'b1;
      i++;
    end
    op = s[i];
    i++;
    if ((op < 8'h40 && (op % 8) < 4) || (op >= 8'h84 && op <= 8'h8B)) begin
      r.w = op[0]; r.d = op[1]; r.w_in = 1'b1; need_modrm = 1'b1;
    end else if ((op >= 8'h40 && op <= 8'h5F) || (op >= 8'h90 && op <= 8'h97)) begin
      r.reg_f = 3'(op % 8);
    end else if (op >= 8'hB0 && op <= 8'hBF) begin
      r.reg_f = 3'(op % 8); r.w = (op >= 8'hB8); r.w_in = 1'b1;
`ifdef DECODE_TWO_BYTE_OPCODE_EN
    end else if (op == 8'h0F) begin
      op = s[i];
      i++;
      if (op inside {8'hB6, 8'hB7, 8'hBE, 8'hBF}) begin
        r.w_in = 1'b1; r.w = 1'b1; r.d = 1'b1; need_modrm = 1'b1;
      end else begin
        r.err = 1'b1;
        used = i;
        return;
      end
`endif
    end else begin
      r.err = 1'b1;
      used = i;
      return;
    end
    if (need_modrm) begin
      m = s[i];
      i++;
      r.reg_f = 3'(m / 8); r.mod = 2'(m / 64); r.rm = 3'(m % 8); r.hm = 1'b1;
    end
    r.bw = (cs != os) ? 2'b10 : 2'b01;
    used = i;
  endtask

  always @(negedge clock) begin
    if (!reset && chk_en) begin
      if (out_valid)
        check("result", 32'({error, bit_width, register, w_in_instruction, w, d,
                             has_modrm, mod, rm}), 32'(exp_r));
      if (error) begin
        check("error_expected", 32'(exp_r.err), 32'd1);
        check("error_quiet", {30'd0, byte_ready, out_valid}, 32'd0);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int bubbles);
    repeat (bubbles) begin
      byte_valid = 1'b0;
      byte_data  = 8'($urandom);
      start      = 1'($urandom_range(0, 1));
      @(posedge clock); #1;
    end
    start = 1'b0;
    byte_valid = 1'b1;
    byte_data = b;
    @(negedge clock);
    check("byte_ready", 32'(byte_ready), 32'd1);
    @(posedge clock); #1;
    byte_valid = 1'b0;
  endtask

  task automatic run_instr(input logic cs, input int hold, input logic b2b, input int max_bubble);
    res_t r;
    int used;
    int cnt;
    model(seq, cs, r, used);
    code_segment_d = cs;
    if (!in_opcode) begin
      start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
    end
    exp_r = r;
    chk_en = 1'b1;
    for (int i = 0; i < used; i++) send_byte(seq[i], $urandom_range(0, max_bubble));
    @(negedge clock);
    if (r.err) begin
      check("error_latency", 32'(error), 32'd1);
      in_opcode = 1'b0;
    end else begin
      check("valid_latency", 32'(out_valid), 32'd1);
      cnt = 0;
      while (1) begin
        out_ready = (cnt >= hold) && (cnt >= hold + 8 || $urandom_range(0, 1) == 1);
        start = out_ready && b2b;
        @(posedge clock); #1;
        if (out_ready) break;
        cnt++;
        @(negedge clock);
      end
      out_ready = 1'b0;
      start = 1'b0;
      in_opcode = b2b;
      if (!b2b) begin
        @(negedge clock);
        check("idle_after_handshake", {30'd0, out_valid, byte_ready}, 32'd0);
      end
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < 16; i++) seq[i] = 8'($urandom);
  endtask

  task automatic pin(input string nm, input logic cs, input res_t lit, input int lit_used);
    res_t r;
    int used;
    model(seq, cs, r, used);
    check(nm, 32'(r), 32'(lit));
    check({nm, "_len"}, 32'(used), 32'(lit_used));
  endtask

  task automatic gen_random();
    logic [7:0] ptab[11] = '{8'h66, 8'h67, 8'hF0, 8'hF2, 8'hF3, 8'h26, 8'h2E,
                             8'h36, 8'h3E, 8'h64, 8'h65};
    logic [7:0] itab[8] = '{8'hD6, 8'hC3, 8'hF4, 8'h8C, 8'h04, 8'h60, 8'h0F, 8'hA5};
    logic [7:0] etab[4] = '{8'hB6, 8'hB7, 8'hBE, 8'hBF};
    int np;
    int k;
    fill_random();
    np = ($urandom_range(0, 9) == 0) ? 5 : $urandom_range(0, 4);
    for (int i = 0; i < np; i++) seq[i] = ptab[$urandom_range(0, 10)];
    k = np;
    case ($urandom_range(0, 6))
      0: seq[k] = 8'($urandom) & 8'h3B;
      1: seq[k] = 8'h84 + 8'($urandom_range(0, 7));
      2: seq[k] = 8'h40 + 8'($urandom_range(0, 31));
      3: seq[k] = 8'h90 + 8'($urandom_range(0, 7));
      4: seq[k] = 8'hB0 + 8'($urandom_range(0, 15));
      5: begin
        seq[k] = 8'h0F;
        if ($urandom_range(0, 3) != 0) seq[k+1] = etab[$urandom_range(0, 3)];
      end
      default: seq[k] = itab[$urandom_range(0, 7)];
    endcase
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("reset_outputs", 32'({byte_ready, out_valid, error, bit_width, register, w_in_instruction,
                                w, d, has_modrm, mod, rm}), 32'd0);

    fill_random(); seq[0] = 8'h01; seq[1] = 8'hD8;
    pin("pin_01_d8", 1'b1, res_t'(15'b0_10_011_1_1_0_1_11_000), 2);
    run_instr(1'b1, 0, 1'b0, 0);

    fill_random(); seq[0] = 8'h66; seq[1] = 8'h66; seq[2] = 8'hB3;
    pin("pin_66_66_b3", 1'b1, res_t'(15'b0_01_011_1_0_0_0_00_000), 3);
    run_instr(1'b1, 0, 1'b0, 1);

    fill_random(); seq[0] = 8'h57;
    pin("pin_57", 1'b0, res_t'(15'b0_01_111_0_0_0_0_00_000), 1);
    run_instr(1'b0, 5, 1'b0, 0);

    fill_random(); seq[0] = 8'h66; seq[1] = 8'hF3; seq[2] = 8'h2E; seq[3] = 8'h26; seq[4] = 8'h64;
    pin("pin_prefix_overflow", 1'b1, res_t'(15'h4000), 5);
    run_instr(1'b1, 0, 1'b0, 0);

    fill_random(); seq[0] = 8'hD6;
    pin("pin_d6", 1'b1, res_t'(15'h4000), 1);
    run_instr(1'b1, 0, 1'b0, 0);

`ifdef DECODE_TWO_BYTE_OPCODE_EN
    fill_random(); seq[0] = 8'h0F; seq[1] = 8'hB6; seq[2] = 8'hC1;
    pin("pin_0f_b6_c1", 1'b1, res_t'(15'b0_10_000_1_1_1_1_11_001), 3);
`else
    fill_random(); seq[0] = 8'h0F;
    pin("pin_0f_off", 1'b1, res_t'(15'h4000), 1);
`endif
    run_instr(1'b1, 0, 1'b0, 0);

    // Back-to-back: start during the completing handshake, then four prefixes must still be legal.
    fill_random(); seq[0] = 8'h90;
    run_instr(1'b0, 2, 1'b1, 0);
    fill_random(); seq[0] = 8'h66; seq[1] = 8'h67; seq[2] = 8'hF0; seq[3] = 8'h65; seq[4] = 8'h89;
    seq[5] = 8'h45;
    run_instr(1'b1, 0, 1'b0, 0);

    for (int n = 0; n < 300; n++) begin
      gen_random();
      run_instr(1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'($urandom_range(0, 1)), 2);
    end

    // Reset in MODRM with a byte offered: reset must win and clear everything.
    chk_en = 1'b0;
    if (!in_opcode) begin
      start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
    end
    send_byte(8'h8B, 0);
    reset = 1'b1;
    byte_valid = 1'b1;
    byte_data = 8'hC0;
    @(posedge clock); #1;
    reset = 1'b0;
    byte_valid = 1'b0;
    @(negedge clock);
    check("reset_in_modrm", 32'({byte_ready, out_valid, error, bit_width, register, w_in_instruction,
                                 w, d, has_modrm, mod, rm}), 32'd0);
    @(negedge clock);
    check("idle_after_reset", {30'd0, byte_ready, out_valid}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
